// File: rtl/rom_reader.sv
// Streams words from a combinational ROM, starting at base_addr, for up to max_len words.
// Latency: one cycle from ROM address to registered out_data; one word per 2 cycles at best.
// Backpressure: out_data/out_valid hold until out_ready; ROM_READER_MARKER_EN enables END_MARKER stop.
module rom_reader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned END_MARKER = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] max_len,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] count
);

`ifdef ROM_READER_MARKER_EN
    localparam bit MARKER_EN = 1'b1;
`else
    localparam bit MARKER_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] MARKER_WORD = DATA_WIDTH'(END_MARKER);
    localparam logic [ADDR_WIDTH-1:0] ONE         = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [ADDR_WIDTH-1:0]   len_q,   len_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q,  data_d;
    logic                    marker_hit;
    logic                    handshake;

    assign marker_hit = MARKER_EN && (read_data == MARKER_WORD);
    assign handshake  = (state_q == OUT) && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    len_d   = max_len;
                    count_d = '0;
                    state_d = (max_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                // A marker word ends the sequence without being emitted or counted.
                if (marker_hit) begin
                    state_d = DONE;
                end else begin
                    data_d  = read_data;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (handshake) begin
                    count_d = count_q + ONE;
                    addr_d  = addr_q + ONE;
                    state_d = (count_d == len_q) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign read_addr = addr_q;
    assign out_data  = data_q;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign count     = count_q;

endmodule

// File: tb/tb_rom_reader.sv
module tb_rom_reader;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] max_len = '0;
    logic [AW-1:0] read_addr;
    logic [AW-1:0] count;
    logic [DW-1:0] read_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] got_q[$];
    logic [AW-1:0] got_addr_q[$];
    int            hs_cyc_q[$];
    int            done_cnt;
    int            done_cyc;
    int            valid_seen;
    int            stall_bad;

    always #5 clk = ~clk;

    rom_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .END_MARKER(255)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .max_len   (max_len),
        .read_addr (read_addr),
        .read_data (read_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    // ROM image: 0..3 count down 3..0; from 4, value/255 pairs 4,255,5,255,...; 0xFFF holds 255.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a <= 12'd3)
            return DW'(3 - int'(a));
        else if (a <= 12'd19)
            return ((a - 12'd4) % 2 == 0) ? DW'(4 + (int'(a) - 4) / 2) : 8'd255;
        else if (a == 12'hFFF)
            return 8'd255;
        else
            return 8'hA5;
    endfunction

    assign read_data = rom(read_addr);

    task automatic run_seq(input logic [AW-1:0] b, input logic [AW-1:0] l, input int stall, input bit poke);
        logic [DW-1:0] held_dat;
        logic [AW-1:0] held_addr;
        int            stall_left;
        bit            finished;
        got_q.delete();
        got_addr_q.delete();
        hs_cyc_q.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        valid_seen = 0;
        stall_bad  = 0;
        stall_left = stall;
        finished   = 0;
        held_dat   = '0;
        held_addr  = '0;
        out_ready  = 1'b1;
        @(negedge clk);
        base_addr = b;
        max_len   = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = poke && (cyc == 0);
            if (poke && cyc == 0) begin
                base_addr = 12'h100;
                max_len   = 12'd1;
            end
            if (stall_left > 0 && stall_left < stall && !out_valid) stall_bad++;
            if (out_valid) begin
                valid_seen = 1;
                if (stall_left > 0) begin
                    if (stall_left == stall) begin
                        held_dat  = out_data;
                        held_addr = read_addr;
                    end else if (out_data !== held_dat || read_addr !== held_addr) begin
                        stall_bad++;
                    end
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    got_q.push_back(out_data);
                    got_addr_q.push_back(read_addr);
                    hs_cyc_q.push_back(cyc);
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                finished = 1;
            end
        end
        start = 1'b0;
        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL seq_timeout: no done pulse within 200 cycles (base=%0h len=%0d)", b, l);
        end
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 8'd0)  begin n_fail++; $display("FAIL reset_data: got %0h want 0", out_data); end
        n_tests++; if (count !== 12'd0)    begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (read_addr !== 12'd0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", read_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [DW-1:0] exp_w[$];
        exp_w = '{8'd3, 8'd2, 8'd1, 8'd0};
        run_seq(12'h000, 12'd4, 0, 1'b0);
        n_tests++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL basic_nwords: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL basic_word%0d: got %0d want %0d", i, got_q[i], exp_w[i]); end
        end
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            n_tests++;
            if (hs_cyc_q[i] - hs_cyc_q[i-1] !== 2) begin n_fail++; $display("FAIL basic_rate%0d: got %0d cycles want 2", i, hs_cyc_q[i] - hs_cyc_q[i-1]); end
        end
        n_tests++; if (done_cnt !== 1)       begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        n_tests++; if (count !== 12'd4)      begin n_fail++; $display("FAIL basic_count: got %0d want 4", count); end
        n_tests++; if (read_addr !== 12'h004) begin n_fail++; $display("FAIL basic_addr: got %0h want 004", read_addr); end
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL basic_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_marker;
        logic [DW-1:0] exp_w[$];
        logic [AW-1:0] exp_cnt;
        logic [AW-1:0] exp_addr;
`ifdef ROM_READER_MARKER_EN
        exp_w = '{8'd4};
        exp_cnt = 12'd1;
        exp_addr = 12'h005;
`else
        exp_w = '{8'd4, 8'd255, 8'd5, 8'd255, 8'd6, 8'd255, 8'd7, 8'd255};
        exp_cnt = 12'd8;
        exp_addr = 12'h00C;
`endif
        run_seq(12'h004, 12'd8, 0, 1'b0);
        n_tests++; if (got_q.size() !== exp_w.size()) begin n_fail++; $display("FAIL marker_nwords: got %0d want %0d", got_q.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL marker_word%0d: got %0d want %0d", i, got_q[i], exp_w[i]); end
        end
        n_tests++; if (count !== exp_cnt)   begin n_fail++; $display("FAIL marker_count: got %0d want %0d", count, exp_cnt); end
        n_tests++; if (read_addr !== exp_addr) begin n_fail++; $display("FAIL marker_addr: got %0h want %0h", read_addr, exp_addr); end
        n_tests++; if (done_cnt !== 1)      begin n_fail++; $display("FAIL marker_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] exp_w[$];
        exp_w = '{8'd3, 8'd2, 8'd1};
        run_seq(12'h000, 12'd3, 5, 1'b0);
        n_tests++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
        n_tests++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL bp_nwords: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", i, got_q[i], exp_w[i]); end
        end
        n_tests++; if (count !== 12'd3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", count); end
    endtask

    task automatic test_wrap;
        run_seq(12'hFFF, 12'd2, 0, 1'b0);
`ifdef ROM_READER_MARKER_EN
        n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL wrap_nwords: got %0d want 0", got_q.size()); end
        n_tests++; if (read_addr !== 12'hFFF) begin n_fail++; $display("FAIL wrap_addr: got %0h want fff", read_addr); end
        n_tests++; if (count !== 12'd0) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", count); end
`else
        n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL wrap_nwords: got %0d want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_tests++; if (got_q[0] !== 8'd255) begin n_fail++; $display("FAIL wrap_word0: got %0d want 255", got_q[0]); end
            n_tests++; if (got_q[1] !== 8'd3)   begin n_fail++; $display("FAIL wrap_word1: got %0d want 3", got_q[1]); end
            n_tests++; if (got_addr_q[1] !== 12'h000) begin n_fail++; $display("FAIL wrap_addr1: got %0h want 000", got_addr_q[1]); end
        end
        n_tests++; if (read_addr !== 12'h001) begin n_fail++; $display("FAIL wrap_addr: got %0h want 001", read_addr); end
        n_tests++; if (count !== 12'd2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", count); end
`endif
    endtask

    task automatic test_zero_len_and_ignore;
        run_seq(12'h010, 12'd0, 0, 1'b0);
        n_tests++; if (done_cyc !== 0)   begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 0", done_cyc); end
        n_tests++; if (done_cnt !== 1)   begin n_fail++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt); end
        n_tests++; if (valid_seen !== 0) begin n_fail++; $display("FAIL zero_valid: got %0d want 0", valid_seen); end
        n_tests++; if (count !== 12'd0)  begin n_fail++; $display("FAIL zero_count: got %0d want 0", count); end
        run_seq(12'h001, 12'd2, 0, 1'b1);
        n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL ignore_nwords: got %0d want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_tests++; if (got_q[0] !== 8'd2 || got_q[1] !== 8'd1) begin n_fail++; $display("FAIL ignore_words: got %0d,%0d want 2,1", got_q[0], got_q[1]); end
        end
        n_tests++; if (read_addr !== 12'h003) begin n_fail++; $display("FAIL ignore_addr: got %0h want 003", read_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int  waited;
        int  done_seen;
        logic [DW-1:0] exp_w[$];
        exp_w = '{8'd3, 8'd2, 8'd1, 8'd0};
        out_ready = 1'b0;
        @(negedge clk);
        base_addr = 12'h000; max_len = 12'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_out: got valid %b want 1", out_valid); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got v=%b b=%b d=%b want 0 0 0", out_valid, busy, done); end
        n_tests++; if (out_data !== 8'd0 || count !== 12'd0 || read_addr !== 12'd0) begin n_fail++; $display("FAIL rst_mid_data: got d=%0h c=%0d a=%0h want 0 0 0", out_data, count, read_addr); end
        done_seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        n_tests++; if (done_seen !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", done_seen); end
        run_seq(12'h000, 12'd4, 0, 1'b0);
        n_tests++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL rst_mid_resume_n: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL rst_mid_word%0d: got %0d want %0d", i, got_q[i], exp_w[i]); end
        end
        n_tests++; if (count !== 12'd4) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 4", count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_marker();
        test_backpressure();
        test_wrap();
        test_zero_len_and_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
